// File: rtl/uart_cmd_responder.sv
// -----------------------------------------------------------------------------
// uart_cmd_responder
//
// Device-side responder for a byte-framed register-access protocol carried
// over a UART link. The host sends 5-byte requests:
//   SYNC_REQ, CMD, ADDR, DATA, CHK   (CHK = CMD ^ ADDR ^ DATA)
// with CMD 8'h01 = write and 8'h02 = read. The block performs one access on a
// simple synchronous register bus and answers with a 4-byte response:
//   SYNC_RSP, STATUS, RDATA, RCHK    (RCHK = STATUS ^ RDATA)
// STATUS 8'h00 = ok, 8'hE1 = checksum error, 8'hE2 = unknown command.
//
// Handshakes (one rule for both FIFOs): a strobe (rd_uart / wr_uart) is a
// single-cycle request that is only raised when the FIFO flag allows it
// (rx_empty = 0 for pops, tx_full = 0 for pushes); the FIFO performs the
// transfer on the clock edge that ends the strobe cycle. A popped byte
// appears on r_data in the following cycle.
//
// Ports:
//   clk, reset            system clock, asynchronous active-high reset
//   rx_empty, r_data      rx FIFO status / read data (registered FIFO read)
//   rd_uart               rx FIFO pop strobe
//   tx_full               tx FIFO full flag
//   w_data, wr_uart       tx FIFO write data / push strobe
//   reg_addr, reg_wdata   register bus address / write data
//   reg_we, reg_re        single-cycle write / read strobes
//   reg_rdata             register read data, valid the cycle after reg_re
//   busy                  high whenever the FSM is not hunting for a frame
//   err_cnt               saturating count of rejected or abandoned frames
// -----------------------------------------------------------------------------
module uart_cmd_responder #(
  parameter int          TIMEOUT_CYCLES = 100000,
  parameter logic [7:0]  SYNC_REQ       = 8'hA5,
  parameter logic [7:0]  SYNC_RSP       = 8'h5A
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx_empty,
  input  logic [7:0] r_data,
  output logic       rd_uart,
  input  logic       tx_full,
  output logic [7:0] w_data,
  output logic       wr_uart,
  output logic [7:0] reg_addr,
  output logic [7:0] reg_wdata,
  output logic       reg_we,
  output logic       reg_re,
  input  logic [7:0] reg_rdata,
  output logic       busy,
  output logic [7:0] err_cnt
);

  // FSM encoding. Receive states are numerically below S_EXEC and transmit
  // states at or above S_SEND_SYNC, so phase decodes are simple compares.
  localparam logic [3:0] S_HUNT      = 4'd0;
  localparam logic [3:0] S_GET_CMD   = 4'd1;
  localparam logic [3:0] S_GET_ADDR  = 4'd2;
  localparam logic [3:0] S_GET_DATA  = 4'd3;
  localparam logic [3:0] S_GET_CHK   = 4'd4;
  localparam logic [3:0] S_EXEC      = 4'd5;
  localparam logic [3:0] S_RD_CAP    = 4'd6;  // read data capture cycle
  localparam logic [3:0] S_SEND_SYNC = 4'd7;
  localparam logic [3:0] S_SEND_STAT = 4'd8;
  localparam logic [3:0] S_SEND_DATA = 4'd9;
  localparam logic [3:0] S_SEND_CHK  = 4'd10;

  localparam logic [7:0] CMD_WRITE  = 8'h01;
  localparam logic [7:0] CMD_READ   = 8'h02;
  localparam logic [7:0] STAT_OK    = 8'h00;
  localparam logic [7:0] STAT_CHK   = 8'hE1;
  localparam logic [7:0] STAT_CMD   = 8'hE2;

  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  logic [3:0]    state;
  logic          fetch_pend;   // a pop was issued last cycle; r_data is valid now
  logic [7:0]    cmd_r;
  logic [7:0]    addr_r;
  logic [7:0]    data_r;
  logic [7:0]    chk_r;
  logic [7:0]    status_r;
  logic [7:0]    rdata_r;
  logic [TW-1:0] tmo_cnt;
  logic [7:0]    err_r;

  logic rx_phase;
  logic tx_phase;
  logic in_frame;
  logic capture;
  logic chk_ok;
  logic is_write;
  logic is_read;
  logic tmo_hit;

  assign rx_phase = (state <= S_GET_CHK);
  assign tx_phase = (state >= S_SEND_SYNC);
  assign in_frame = (state >= S_GET_CMD) && (state <= S_GET_CHK);
  assign capture  = fetch_pend;
  assign chk_ok   = ((cmd_r ^ addr_r ^ data_r) == chk_r);
  assign is_write = (cmd_r == CMD_WRITE);
  assign is_read  = (cmd_r == CMD_READ);
  assign tmo_hit  = in_frame && !capture && (tmo_cnt == TMO_LAST);

  // Pops are combinational so rx_empty is checked in the very cycle the
  // strobe is high; the fetch_pend gap cycle limits the rate to one byte
  // per two cycles. Gated by reset so a non-empty FIFO is never drained
  // while the block is held in reset.
  assign rd_uart = !reset && rx_phase && !fetch_pend && !rx_empty;

  // Pushes likewise track tx_full in the same cycle; a full FIFO simply
  // holds the FSM in its current send state.
  assign wr_uart = tx_phase && !tx_full;

  always_comb begin
    w_data = 8'h00;
    case (state)
      S_SEND_SYNC: w_data = SYNC_RSP;
      S_SEND_STAT: w_data = status_r;
      S_SEND_DATA: w_data = rdata_r;
      S_SEND_CHK:  w_data = status_r ^ rdata_r;
      default:     w_data = 8'h00;
    endcase
  end

  // Register bus strobes are only decoded in EXEC, and the write and read
  // decodes are mutually exclusive on cmd_r, so they can never overlap.
  assign reg_we    = (state == S_EXEC) && chk_ok && is_write;
  assign reg_re    = (state == S_EXEC) && chk_ok && is_read;
  assign reg_addr  = addr_r;
  assign reg_wdata = data_r;

  assign busy    = (state != S_HUNT);
  assign err_cnt = err_r;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_pend <= 1'b0;
    end else begin
      // A pop this cycle means valid data next cycle; otherwise nothing pending.
      fetch_pend <= rd_uart;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= S_HUNT;
      cmd_r    <= 8'h00;
      addr_r   <= 8'h00;
      data_r   <= 8'h00;
      chk_r    <= 8'h00;
      status_r <= 8'h00;
      rdata_r  <= 8'h00;
      tmo_cnt  <= '0;
      err_r    <= 8'h00;
    end else begin
      // Inter-byte timer: restarts on every captured byte inside a frame and
      // only runs while a frame is partially received.
      if (!in_frame || capture || tmo_hit) begin
        tmo_cnt <= '0;
      end else begin
        tmo_cnt <= tmo_cnt + TW'(1);
      end

      case (state)
        S_HUNT: begin
          // Non-sync bytes are dropped without being counted as errors.
          if (capture && (r_data == SYNC_REQ)) begin
            state <= S_GET_CMD;
          end
        end

        // Inside a frame every byte is payload, including SYNC_REQ values.
        S_GET_CMD: begin
          if (capture) begin
            cmd_r <= r_data;
            state <= S_GET_ADDR;
          end else if (tmo_hit) begin
            err_r <= sat_inc(err_r);
            state <= S_HUNT;
          end
        end

        S_GET_ADDR: begin
          if (capture) begin
            addr_r <= r_data;
            state  <= S_GET_DATA;
          end else if (tmo_hit) begin
            err_r <= sat_inc(err_r);
            state <= S_HUNT;
          end
        end

        S_GET_DATA: begin
          if (capture) begin
            data_r <= r_data;
            state  <= S_GET_CHK;
          end else if (tmo_hit) begin
            err_r <= sat_inc(err_r);
            state <= S_HUNT;
          end
        end

        S_GET_CHK: begin
          if (capture) begin
            chk_r <= r_data;
            state <= S_EXEC;
          end else if (tmo_hit) begin
            err_r <= sat_inc(err_r);
            state <= S_HUNT;
          end
        end

        S_EXEC: begin
          if (!chk_ok) begin
            status_r <= STAT_CHK;
            rdata_r  <= 8'h00;
            err_r    <= sat_inc(err_r);
            state    <= S_SEND_SYNC;
          end else if (!is_write && !is_read) begin
            status_r <= STAT_CMD;
            rdata_r  <= 8'h00;
            err_r    <= sat_inc(err_r);
            state    <= S_SEND_SYNC;
          end else if (is_write) begin
            // reg_we is high this cycle; the response echoes the written data.
            status_r <= STAT_OK;
            rdata_r  <= data_r;
            state    <= S_SEND_SYNC;
          end else begin
            // reg_re is high this cycle; data arrives on the next one.
            status_r <= STAT_OK;
            state    <= S_RD_CAP;
          end
        end

        S_RD_CAP: begin
          rdata_r <= reg_rdata;
          state   <= S_SEND_SYNC;
        end

        S_SEND_SYNC: if (!tx_full) state <= S_SEND_STAT;
        S_SEND_STAT: if (!tx_full) state <= S_SEND_DATA;
        S_SEND_DATA: if (!tx_full) state <= S_SEND_CHK;
        S_SEND_CHK:  if (!tx_full) state <= S_HUNT;

        default: state <= S_HUNT;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_cmd_responder.sv
// -----------------------------------------------------------------------------
// tb_uart_cmd_responder
//
// Self-checking bench for uart_cmd_responder. A behavioural rx FIFO (byte
// memory plus read pointer) feeds request frames, a tx monitor logs every
// pushed byte, and a register-bus monitor counts strobes and returns read
// data one cycle after reg_re. Table-driven frames cover the main function;
// hand-written sequences cover garbage, timeout, backpressure, reset
// mid-response and err_cnt saturation.
// -----------------------------------------------------------------------------
module tb_uart_cmd_responder;

  localparam int TMO = 50;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic       rx_empty;
  logic [7:0] r_data = 8'h00;
  logic       rd_uart;
  logic       tx_full = 1'b0;
  logic [7:0] w_data;
  logic       wr_uart;
  logic [7:0] reg_addr;
  logic [7:0] reg_wdata;
  logic       reg_we;
  logic       reg_re;
  logic [7:0] reg_rdata = 8'h00;
  logic       busy;
  logic [7:0] err_cnt;

  uart_cmd_responder #(
    .TIMEOUT_CYCLES(TMO),
    .SYNC_REQ(8'hA5),
    .SYNC_RSP(8'h5A)
  ) dut (
    .clk(clk),
    .reset(reset),
    .rx_empty(rx_empty),
    .r_data(r_data),
    .rd_uart(rd_uart),
    .tx_full(tx_full),
    .w_data(w_data),
    .wr_uart(wr_uart),
    .reg_addr(reg_addr),
    .reg_wdata(reg_wdata),
    .reg_we(reg_we),
    .reg_re(reg_re),
    .reg_rdata(reg_rdata),
    .busy(busy),
    .err_cnt(err_cnt)
  );

  // ---------------- rx FIFO model ----------------
  // feed_mem/feed_wr are written only by the stimulus tasks, rd_ptr only by
  // the pop process, so the FIFO has a single writer per variable.
  logic [7:0] feed_mem [0:1023];
  int         feed_wr = 0;
  int         rd_ptr  = 0;
  assign rx_empty = (feed_wr <= rd_ptr);

  // ---------------- monitors ----------------
  logic [7:0] tx_log[$];
  int         tx_cyc[$];
  int         cyc           = 0;
  int         we_cnt        = 0;
  int         re_cnt        = 0;
  int         both_cnt      = 0;
  int         we_cyc        = 0;
  int         rd_empty_viol = 0;
  int         wr_full_viol  = 0;
  logic [7:0] last_addr     = 8'h00;
  logic [7:0] last_wdata    = 8'h00;
  logic [7:0] rd_val        = 8'h00;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rd_uart) begin
      if (rx_empty) rd_empty_viol <= rd_empty_viol + 1;
      else begin
        r_data <= feed_mem[rd_ptr];
        rd_ptr <= rd_ptr + 1;
      end
    end
    if (wr_uart) begin
      if (tx_full) wr_full_viol <= wr_full_viol + 1;
      else begin
        tx_log.push_back(w_data);
        tx_cyc.push_back(cyc);
      end
    end
    if (reg_we) begin
      we_cnt     <= we_cnt + 1;
      we_cyc     <= cyc;
      last_addr  <= reg_addr;
      last_wdata <= reg_wdata;
    end
    if (reg_re) begin
      re_cnt    <= re_cnt + 1;
      last_addr <= reg_addr;
      reg_rdata <= rd_val;
    end
    if (reg_we && reg_re) both_cnt <= both_cnt + 1;
  end

  // ---------------- scoreboard ----------------
  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic push_byte(input logic [7:0] b);
    @(negedge clk);
    feed_mem[feed_wr] = b;
    feed_wr           = feed_wr + 1;
  endtask

  task automatic push_frame(input logic [39:0] f);
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      feed_mem[feed_wr] = f[39-8*i -: 8];
      feed_wr           = feed_wr + 1;
    end
  endtask

  task automatic wait_tx(input int base, output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 800; n++) begin
      @(negedge clk);
      if ((tx_log.size() >= base + 4) && !busy) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  function automatic logic [31:0] rsp_word(input int base);
    if (tx_log.size() < base + 4) return 32'h0;
    return {tx_log[base], tx_log[base+1], tx_log[base+2], tx_log[base+3]};
  endfunction

  typedef struct {
    string       tag;
    logic [39:0] frame;
    logic [7:0]  rd;
    logic [31:0] exp_rsp;
    int          exp_we;
    int          exp_re;
    logic [7:0]  exp_addr;
    logic [7:0]  exp_wdata;
    logic [7:0]  exp_err;
  } vec_t;

  task automatic run_vec(input vec_t v);
    int base;
    int we0;
    int re0;
    bit ok;
    base   = tx_log.size();
    we0    = we_cnt;
    re0    = re_cnt;
    rd_val = v.rd;
    push_frame(v.frame);
    wait_tx(base, ok);
    check({v.tag, "/done"}, 32'(ok), 32'd1);
    check({v.tag, "/rsp"}, rsp_word(base), v.exp_rsp);
    check({v.tag, "/we_pulses"}, 32'(we_cnt - we0), 32'(v.exp_we));
    check({v.tag, "/re_pulses"}, 32'(re_cnt - re0), 32'(v.exp_re));
    check({v.tag, "/err_cnt"}, 32'(err_cnt), 32'(v.exp_err));
    if (v.exp_we + v.exp_re > 0) check({v.tag, "/addr"}, 32'(last_addr), 32'(v.exp_addr));
    if (v.exp_we > 0) begin
      check({v.tag, "/wdata"}, 32'(last_wdata), 32'(v.exp_wdata));
      if (tx_cyc.size() > base) check({v.tag, "/we_to_wr"}, 32'(tx_cyc[base] - we_cyc), 32'd1);
    end
  endtask

  // ---------------- test sequence ----------------
  vec_t vecs[6];

  initial begin
    int  base;
    int  we0;
    int  n_bad;
    bit  ok;
    vec_t v;

    vecs[0] = '{"write",     40'hA5_01_10_3C_2D, 8'h00, 32'h5A_00_3C_3C, 1, 0, 8'h10, 8'h3C, 8'd0};
    vecs[1] = '{"read",      40'hA5_02_22_00_20, 8'h99, 32'h5A_00_99_99, 0, 1, 8'h22, 8'h00, 8'd0};
    vecs[2] = '{"bad_chk",   40'hA5_01_10_3C_00, 8'h00, 32'h5A_E1_00_E1, 0, 0, 8'h00, 8'h00, 8'd1};
    vecs[3] = '{"bad_cmd",   40'hA5_07_00_00_07, 8'h00, 32'h5A_E2_00_E2, 0, 0, 8'h00, 8'h00, 8'd2};
    vecs[4] = '{"read_sync", 40'hA5_02_A5_11_B6, 8'h5C, 32'h5A_00_5C_5C, 0, 1, 8'hA5, 8'h00, 8'd2};
    vecs[5] = '{"write_ff",  40'hA5_01_FF_00_FE, 8'h00, 32'h5A_00_00_00, 1, 0, 8'hFF, 8'h00, 8'd2};

    // Reset state; a byte waiting in the rx FIFO must not be popped in reset.
    repeat (2) @(negedge clk);
    push_byte(8'h00);
    @(negedge clk);
    check("rst/rd_uart", 32'(rd_uart), 32'd0);
    check("rst/wr_uart", 32'(wr_uart), 32'd0);
    check("rst/busy", 32'(busy), 32'd0);
    check("rst/err_cnt", 32'(err_cnt), 32'd0);
    check("rst/bus", {reg_addr, reg_wdata, 6'd0, reg_we, reg_re, w_data}, 32'd0);
    reset = 1'b0;

    // Table-driven frames (the leftover 00 byte is dropped silently first).
    foreach (vecs[i]) run_vec(vecs[i]);

    // Garbage before SYNC is discarded without touching err_cnt.
    push_byte(8'h00);
    push_byte(8'hFF);
    push_byte(8'h13);
    v = '{"garbage", 40'hA5_01_33_44_76, 8'h00, 32'h5A_00_44_44, 1, 0, 8'h33, 8'h44, 8'd2};
    run_vec(v);

    // Inter-byte timeout after SYNC + CMD.
    base = tx_log.size();
    push_byte(8'hA5);
    push_byte(8'h01);
    repeat (20) @(negedge clk);
    check("tmo/busy_mid", 32'(busy), 32'd1);
    repeat (60) @(negedge clk);
    check("tmo/busy_after", 32'(busy), 32'd0);
    check("tmo/err_cnt", 32'(err_cnt), 32'd3);
    check("tmo/no_tx", 32'(tx_log.size()), 32'(base));
    v = '{"post_tmo", 40'hA5_02_40_00_42, 8'h7E, 32'h5A_00_7E_7E, 0, 1, 8'h40, 8'h00, 8'd3};
    run_vec(v);

    // Backpressure: response stalls, queued rx bytes stay in the FIFO.
    tx_full = 1'b1;
    base    = tx_log.size();
    we0     = we_cnt;
    rd_val  = 8'h31;
    push_frame(40'hA5_01_55_AA_FE);
    repeat (40) @(negedge clk);
    check("bp/no_push", 32'(tx_log.size()), 32'(base));
    check("bp/busy", 32'(busy), 32'd1);
    check("bp/we_done", 32'(we_cnt - we0), 32'd1);
    push_frame(40'hA5_02_66_00_64);
    repeat (20) @(negedge clk);
    check("bp/rx_held", 32'(feed_wr - rd_ptr), 32'd5);
    tx_full = 1'b0;
    wait_tx(base, ok);
    check("bp/done1", 32'(ok), 32'd1);
    check("bp/rsp1", rsp_word(base), 32'h5A_00_AA_AA);
    wait_tx(base + 4, ok);
    check("bp/done2", 32'(ok), 32'd1);
    check("bp/rsp2", rsp_word(base + 4), 32'h5A_00_31_31);
    check("bp/wr_full_viol", 32'(wr_full_viol), 32'd0);

    // Reset after the second pushed response byte.
    base = tx_log.size();
    push_frame(40'hA5_01_12_34_27);
    ok = 1'b0;
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      if (tx_log.size() >= base + 2) begin
        ok = 1'b1;
        break;
      end
    end
    check("mid_rst/reached", 32'(ok), 32'd1);
    reset = 1'b1;
    #1;
    check("mid_rst/wr_uart", 32'(wr_uart), 32'd0);
    check("mid_rst/busy", 32'(busy), 32'd0);
    check("mid_rst/err_cnt", 32'(err_cnt), 32'd0);
    check("mid_rst/bus", {reg_addr, reg_wdata, 6'd0, reg_we, reg_re, w_data}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (30) @(negedge clk);
    check("mid_rst/no_more_tx", 32'(tx_log.size()), 32'(base + 2));
    v = '{"post_rst", 40'hA5_01_20_0F_2E, 8'h00, 32'h5A_00_0F_0F, 1, 0, 8'h20, 8'h0F, 8'd0};
    run_vec(v);

    // err_cnt saturation with unknown-command frames (checksum is valid).
    n_bad = 0;
    for (int k = 0; k < 256; k++) begin
      base = tx_log.size();
      push_frame(40'hA5_00_00_00_00);
      wait_tx(base, ok);
      if (!ok) n_bad++;
      if (k == 254) check("sat/err_at_255", 32'(err_cnt), 32'd255);
    end
    check("sat/all_answered", 32'(n_bad), 32'd0);
    check("sat/err_held", 32'(err_cnt), 32'd255);

    check("global/rd_while_empty", 32'(rd_empty_viol), 32'd0);
    check("global/we_and_re", 32'(both_cnt), 32'd0);
    check("global/wr_while_full", 32'(wr_full_viol), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/uart_cmd_responder.md
Name: uart_cmd_responder

Overview:
- Device-side responder for a byte-framed register-access protocol carried over the UART link; the host is the initiator.
- Pops request bytes from the UART rx FIFO and parses 5-byte request frames.
- Performs one register read or write on a simple synchronous register bus.
- Pushes a 4-byte response frame into the UART tx FIFO.

Parameters:
- TIMEOUT_CYCLES, 100000: maximum clk cycles allowed between consecutive request bytes inside a frame.
- SYNC_REQ, 8'hA5: request start byte.
- SYNC_RSP, 8'h5A: response start byte.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- rx_empty  in  1  rx FIFO empty flag
- r_data  in  8  rx FIFO read data; valid the cycle after rd_uart (registered FIFO read)
- rd_uart  out  1  rx FIFO pop strobe
- tx_full  in  1  tx FIFO full flag
- w_data  out  8  tx FIFO write data
- wr_uart  out  1  tx FIFO push strobe
- reg_addr  out  8  register bus address
- reg_wdata  out  8  register bus write data
- reg_we  out  1  register write strobe, 1 cycle
- reg_re  out  1  register read strobe, 1 cycle
- reg_rdata  in  8  register read data, valid the cycle after reg_re
- busy  out  1  high whenever state is not HUNT
- err_cnt  out  8  count of rejected frames, saturating

Behaviour:
- Reset: asynchronous, active-high.
  - State goes to HUNT.
  - rd_uart, wr_uart, reg_we, reg_re, busy are 0.
  - w_data, reg_addr, reg_wdata, err_cnt are 0.
  - The timeout counter and all frame registers clear.
  - A reset mid-frame or mid-response discards the frame; no partial response is completed after reset.
- Request frame: SYNC_REQ, CMD, ADDR, DATA, CHK, where CHK = CMD^ADDR^DATA.
  - CMD 8'h01 = write, 8'h02 = read.
  - DATA is don't-care for reads but still counts in CHK.
- Response frame: SYNC_RSP, STATUS, RDATA, RCHK, where RCHK = STATUS^RDATA.
  - STATUS 8'h00 = ok, 8'hE1 = checksum error, 8'hE2 = unknown CMD.
  - RDATA = read data for a read, echoed DATA for a write, 8'h00 on error.
- Byte fetch (all receive states):
  - When rx_empty=0 and no fetch is pending, assert rd_uart for exactly 1 cycle.
  - Sample r_data the next cycle; rd_uart stays low in that cycle.
  - Maximum rate: one byte per 2 cycles.
  - rd_uart is never asserted while rx_empty=1.
- States and transitions:
  - HUNT: fetch bytes; a byte != SYNC_REQ is discarded silently (no err_cnt change). SYNC_REQ -> GET_CMD.
  - GET_CMD -> GET_ADDR -> GET_DATA -> GET_CHK: one byte each.
  - GET_CHK -> EXEC once the CHK byte is captured.
  - EXEC, checks in priority order:
    - checksum mismatch -> STATUS=E1;
    - else CMD not 01/02 -> STATUS=E2;
    - else write: reg_we=1 for 1 cycle with reg_addr=ADDR, reg_wdata=DATA;
    - else read: reg_re=1 for 1 cycle, capture reg_rdata the next cycle.
    - An E1 or E2 outcome increments err_cnt, saturating at 8'hFF.
    - Then -> SEND_SYNC.
  - SEND_SYNC, SEND_STAT, SEND_DATA, SEND_CHK: each pushes one byte.
    - wr_uart=1 for 1 cycle with w_data set only when tx_full=0; otherwise hold state, with no timeout.
    - Back-to-back pushes are allowed.
    - SEND_CHK -> HUNT after its push.
- Timeout:
  - In GET_CMD through GET_CHK, the counter resets on every captured byte and increments each cycle otherwise.
  - When it reaches TIMEOUT_CYCLES: abandon the frame, increment err_cnt (saturating), go to HUNT, send no response.
  - No timeout in HUNT, EXEC or SEND states.
- Latency: a write with an idle tx FIFO drives reg_we 1 cycle after CHK capture; the first wr_uart follows 1 cycle later.
- Rx bytes arriving during EXEC or the SEND states remain in the rx FIFO; they are not popped until HUNT.
- A SYNC_REQ value in GET_CMD..GET_CHK is treated as ordinary data (no resync).
- reg_we and reg_re are never both high; neither is asserted outside EXEC.

Test Plan:
- Write: feed A5 01 10 3C 2D -> single reg_we pulse with addr 8'h10 and wdata 8'h3C; tx bytes 5A 00 3C 3C; err_cnt stays 0.
- Read: feed A5 02 22 00 20 with reg_rdata=8'h99 -> single reg_re pulse with addr 8'h22; tx bytes 5A 00 99 99.
- Bad checksum, then unknown CMD:
  - A5 01 10 3C 00 -> no reg_we; tx 5A E1 00 E1; err_cnt=1.
  - A5 07 00 00 07 -> tx 5A E2 00 E2; err_cnt=2.
- Garbage then timeout:
  - Bytes 00 FF 13 before A5 are dropped silently.
  - After A5 01, stall TIMEOUT_CYCLES (set to 50) -> busy falls, err_cnt+1, no wr_uart; a following valid frame is answered normally.
- Backpressure: hold tx_full=1 during the response -> wr_uart stays 0 and state holds. Release tx_full -> 4 bytes pushed in order; rd_uart is never asserted while rx_empty=1.
- Reset mid-response: assert reset after the 2nd pushed byte -> all outputs 0 immediately; after release, no further pushes until a new frame arrives.
